// File: rtl/seven_segment_scanner.sv
// Captures a signed value, converts its magnitude to BCD one bit per cycle and
// time-multiplexes four sign/blank/overflow-coded digits onto en/num.
module seven_segment_scanner #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_value,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overflow,
    output logic [1:0]        o_en,
    output logic [3:0]        o_num
);

    localparam int unsigned  IterW    = $clog2(DATA_W);
    localparam int unsigned  RefW     = $clog2(REFRESH_DIV);
    localparam logic [IterW-1:0] LastIter = IterW'(DATA_W - 1);
    localparam logic [RefW-1:0]  RefLast  = RefW'(REFRESH_DIV - 1);
    localparam logic [3:0]   CodeDash  = 4'd10;
    localparam logic [3:0]   CodeBlank = 4'd15;

    typedef enum logic [1:0] {
        StIdle,
        StConvert,
        StCommit
    } state_e;

    state_e            r_state;
    logic [DATA_W-1:0] r_mag;
    logic [19:0]       r_bcd;
    logic [IterW-1:0]  r_iter;
    logic              r_neg;
    logic              r_busy;
    logic              r_done;
    logic              r_overflow;
    logic [3:0]        r_digit [4];
    logic [RefW-1:0]   r_ref_cnt;
    logic [1:0]        r_en;

    logic [DATA_W-1:0] w_abs;
    logic [19:0]       w_bcd_adj;
    logic              w_ovf;
    logic [3:0]        w_d0;
    logic [3:0]        w_d1;
    logic [3:0]        w_d2;
    logic [3:0]        w_d3;

    // Subtracting from zero also maps the most negative value onto 2^(DATA_W-1).
    always_comb begin
        w_abs = i_value;
        if (i_value[DATA_W-1]) begin
            w_abs = DATA_W'(0) - i_value;
        end
    end

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 5; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        w_ovf = |r_bcd[19:12];
        w_d0  = r_bcd[3:0];
        w_d1  = r_bcd[7:4];
        w_d2  = r_bcd[11:8];
        w_d3  = r_neg ? CodeDash : CodeBlank;
        if (r_bcd[11:8] == 4'd0) begin
            w_d2 = CodeBlank;
            if (r_bcd[7:4] == 4'd0) begin
                w_d1 = CodeBlank;
            end
        end
        if (w_ovf) begin
            w_d0 = CodeDash;
            w_d1 = CodeDash;
            w_d2 = CodeDash;
            w_d3 = CodeDash;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_mag      <= '0;
            r_bcd      <= '0;
            r_iter     <= '0;
            r_neg      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_digit[0] <= 4'd0;
            r_digit[1] <= CodeBlank;
            r_digit[2] <= CodeBlank;
            r_digit[3] <= CodeBlank;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_mag   <= w_abs;
                        r_neg   <= i_value[DATA_W-1];
                        r_bcd   <= '0;
                        r_iter  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StConvert;
                    end
                end
                StConvert: begin
                    {r_bcd, r_mag} <= {w_bcd_adj, r_mag} << 1;
                    r_iter         <= r_iter + 1'b1;
                    if (r_iter == LastIter) begin
                        r_state <= StCommit;
                    end
                end
                StCommit: begin
                    r_digit[0] <= w_d0;
                    r_digit[1] <= w_d1;
                    r_digit[2] <= w_d2;
                    r_digit[3] <= w_d3;
                    r_overflow <= w_ovf;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                    r_state    <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Refresh runs on its own; it never waits on a conversion.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ref_cnt <= '0;
            r_en      <= 2'd0;
        end else if (r_ref_cnt == RefLast) begin
            r_ref_cnt <= '0;
            r_en      <= r_en + 2'd1;
        end else begin
            r_ref_cnt <= r_ref_cnt + 1'b1;
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_overflow = r_overflow;
    assign o_en       = r_en;
    assign o_num      = r_digit[r_en];

endmodule
